risc1_mem_initiator: RTL and testbench
======================================

# risc1_mem_initiator

Initiator side of the risc1 memory access handshake. It takes single byte load/store requests from the CPU core through a valid/ready port and drives the memory bus strobes (read, write, address, write_value). It then completes the four-phase handshake against the memory responder's ready line and returns one response per request. A per-transaction watchdog reports a responder that never answers or never releases.

## Interface
Parameters:
- ADDR_W, default `ARCH_SIZE: address width, matching the bus address.
- DATA_W, default 8: data width (one byte, matching the responder's storage).
- TIMEOUT_CYCLES, default 64: cycles allowed in ISSUE+RELEASE before abort; 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  initiator accepts the request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_W  load data; 0 for stores and errors
- resp_error  out  1  watchdog abort; valid with resp_valid
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- mem_address  out  ADDR_W  bus address
- mem_write_value  out  DATA_W  bus write data
- mem_read_value  in  DATA_W  responder data
- mem_ready  in  1  responder completion level

## Operation
- FSM states: IDLE, ISSUE, RELEASE, DONE.
- IDLE:
  - req_ready = (mem_ready == 0).
  - On req_valid && req_ready: latch write/addr/wdata; go to ISSUE.
- ISSUE:
  - mem_read = !write; mem_write = write; address and write_value come from the latches.
  - When mem_ready is sampled 1: capture mem_read_value if a load, else capture 0; go to RELEASE.
- RELEASE:
  - Both strobes 0.
  - When mem_ready is sampled 0: go to DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle, with resp_rdata/resp_error; then go to IDLE.
- Never assert mem_read and mem_write together. Strobes are only high in ISSUE.
- mem_address/mem_write_value hold their latched values through RELEASE. They return to 0 only on reset.
- Watchdog:
  - A counter clears on entry to ISSUE and increments every cycle in ISSUE or RELEASE.
  - When it reaches TIMEOUT_CYCLES (≠0): go to DONE with resp_error = 1 and resp_rdata = 0; strobes drop the same edge.
  - Watchdog abort takes priority over a simultaneous mem_ready transition.
- A stale mem_ready held high blocks acceptance in IDLE; no request is lost, it waits.
- The core may drop req_valid at any time without handshake.

## Timing
- Reset, asynchronous: state = IDLE, counter = 0, and all outputs 0: mem_read, mem_write, mem_address, mem_write_value, resp_valid, resp_rdata, resp_error. req_ready follows IDLE rule immediately after reset.
- Accept at edge E0. Strobes are high after E0.
- With a zero-wait responder (ready rises within the same cycle), the sequence after accept at E0 is:
  - ISSUE→RELEASE at E1.
  - RELEASE→DONE at E2, once ready falls.
  - resp_valid high between E2 and E3.
  - req_ready high again after E3.
- Minimum request-to-response latency: 3 cycles. Throughput: one transaction per 4 cycles.
- Each additional responder wait cycle in either phase adds 1 cycle.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. Comparison is unsigned, with no wrap.
- Reset asserted mid-transaction: strobes drop asynchronously and no response is produced.

## Structure
- Package risc1_mem_pkg holds:
  - the state enum (mem_init_state_t: IDLE, ISSUE, RELEASE, DONE);
  - the ARCH_SIZE-derived address typedef mem_addr_t;
  - the byte data typedef mem_data_t.
- One sub-module: risc1_mem_watchdog (clear, enable, expired; parameter TIMEOUT_CYCLES).
- Everything else is flat in risc1_mem_initiator.

## Test plan
- Store 123 to address 102, zero-wait responder: mem_write high 1 cycle then low; resp_valid at cycle 3 with resp_error=0, resp_rdata=0.
- Load from 102 after that store: mem_read high; resp_rdata=123 at cycle 3; mem_write never asserted.
- Responder delays ready 5 cycles in ISSUE and 2 cycles in RELEASE: resp_valid at cycle 10, data correct, strobes held steady while waiting.
- Watchdog: TIMEOUT_CYCLES=8, responder never raises ready: resp_valid with resp_error=1, resp_rdata=0 at cycle 9; strobes 0 afterwards.
- Stale ready: mem_ready held 1 while req_valid=1 in IDLE: req_ready=0, no strobe. mem_ready→0: accept next cycle.
- Reset_n pulsed low while in ISSUE: mem_read drops without waiting for clk, no resp_valid; next request completes normally.

Source files
------------

// File: rtl/risc1_mem_pkg.sv
// Shared types for the risc1 memory initiator: FSM state encoding and bus address/data types.
`ifndef ARCH_SIZE
`define ARCH_SIZE 16
`endif

package risc1_mem_pkg;

  localparam int unsigned ARCH_SIZE = `ARCH_SIZE;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE,
    DONE
  } mem_init_state_t;

  typedef logic [ARCH_SIZE-1:0] mem_addr_t;
  typedef logic [BYTE_W-1:0]    mem_data_t;

endpackage

// File: rtl/risc1_mem_watchdog.sv
// Per-transaction cycle counter; flags the edge at which the count reaches TIMEOUT_CYCLES.
module risc1_mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Asserted one count early so the abort lands on the edge where the count hits the limit.
  always_comb begin
    expired = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      expired = enable && (count == LIMIT - 1'b1);
    end
  end

endmodule

// File: rtl/risc1_mem_initiator.sv
// Initiator side of the risc1 memory handshake: accepts byte load/store requests, runs the
// four-phase strobe/ready exchange with the responder and returns one response per request.
module risc1_mem_initiator
  import risc1_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = $bits(mem_addr_t),
  parameter int unsigned DATA_W         = $bits(mem_data_t),
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_value,
  input  logic [DATA_W-1:0] mem_read_value,
  input  logic              mem_ready
);

  mem_init_state_t state, state_next;

  logic              write_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              accept, capture, abort;
  logic              in_flight, wd_expired;

  assign in_flight = (state == ISSUE) || (state == RELEASE);

  risc1_mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .enable (in_flight),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes decode from state so an asynchronous reset drops them without waiting for clk.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_error = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !mem_ready;
        if (req_valid && !mem_ready) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_read  = !write_q;
        mem_write = write_q;
        if (wd_expired) begin
          abort      = 1'b1;
          state_next = DONE;
        end else if (mem_ready) begin
          capture    = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (wd_expired) begin
          abort      = 1'b1;
          state_next = DONE;
        end else if (!mem_ready) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_error = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q         <= 1'b0;
      mem_address     <= '0;
      mem_write_value <= '0;
      rdata_q         <= '0;
      err_q           <= 1'b0;
    end else if (accept) begin
      write_q         <= req_write;
      mem_address     <= req_addr;
      mem_write_value <= req_wdata;
      rdata_q         <= '0;
      err_q           <= 1'b0;
    end else if (abort) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end else if (capture) begin
      rdata_q <= write_q ? '0 : mem_read_value;
    end
  end

endmodule

// File: tb/tb_risc1_mem_initiator.sv
// Directed bench for risc1_mem_initiator with a cycle-stepped responder model driven from tasks.
module tb_risc1_mem_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid, resp_error;
  logic [7:0]  resp_rdata;
  logic        mem_read, mem_write, mem_ready;
  logic [15:0] mem_address;
  logic [7:0]  mem_write_value, mem_read_value;

  logic        w_req_valid, w_req_ready, w_req_write;
  logic [15:0] w_req_addr;
  logic [7:0]  w_req_wdata;
  logic        w_resp_valid, w_resp_error;
  logic [7:0]  w_resp_rdata;
  logic        w_mem_read, w_mem_write, w_mem_ready;
  logic [15:0] w_mem_address;
  logic [7:0]  w_mem_write_value, w_mem_read_value;

  logic [7:0] mem_model [0:255];

  int checks = 0;
  int errors = 0;

  risc1_mem_initiator #(
    .ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_value(mem_write_value), .mem_read_value(mem_read_value),
    .mem_ready(mem_ready)
  );

  risc1_mem_initiator #(
    .ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(8)
  ) dut_wd (
    .clk(clk), .reset_n(reset_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_error(w_resp_error),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_address(w_mem_address),
    .mem_write_value(w_mem_write_value), .mem_read_value(w_mem_read_value),
    .mem_ready(w_mem_ready)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                         input int idly, input int rdly, input int exp_lat,
                         input logic [7:0] exp_rd, input string tag);
    int   cyc, iw, rw, strobes, bad;
    logic done;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    #1 check_val({tag, " req_ready"}, req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; iw = 0; rw = 0; strobes = 0; bad = 0; done = 1'b0;
    while (!done && cyc <= 40) begin
      if (resp_valid) begin
        done = 1'b1;
      end else begin
        if (mem_read || mem_write) begin
          strobes++;
          if (mem_write !== wr || mem_read !== !wr || mem_address !== addr ||
              (wr && mem_write_value !== wd)) bad++;
          if (iw >= idly) begin
            mem_ready = 1'b1;
            if (wr) mem_model[addr[7:0]] = mem_write_value;
            else    mem_read_value = mem_model[addr[7:0]];
          end else begin
            iw++;
          end
        end else if (mem_ready) begin
          if (mem_address !== addr) bad++;
          if (rw >= rdly) mem_ready = 1'b0;
          else            rw++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check_val({tag, " latency"}, done ? cyc : 0, exp_lat);
    check_val({tag, " resp_error"}, resp_error, 0);
    check_val({tag, " resp_rdata"}, resp_rdata, exp_rd);
    check_val({tag, " strobe_cycles"}, strobes, idly + 1);
    check_val({tag, " strobe_hold"}, bad, 0);
    check_val({tag, " addr_hold"}, mem_address, addr);
    @(negedge clk);
    check_val({tag, " ready_again"}, req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, strobes, pulses;
    logic done;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_read_value = '0;
    w_req_valid = 1'b0; w_req_write = 1'b0; w_req_addr = '0; w_req_wdata = '0;
    w_mem_ready = 1'b0; w_mem_read_value = 8'hFF;

    @(negedge clk);
    @(negedge clk);
    check_val("rst mem_read", mem_read, 0);
    check_val("rst mem_write", mem_write, 0);
    check_val("rst mem_address", mem_address, 0);
    check_val("rst mem_write_value", mem_write_value, 0);
    check_val("rst resp_valid", resp_valid, 0);
    check_val("rst resp_rdata", resp_rdata, 0);
    check_val("rst resp_error", resp_error, 0);
    check_val("rst req_ready", req_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 16'd102, 8'd123, 0, 0, 3, 8'd0,   "st_zw");
    run_txn(1'b0, 16'd102, 8'd0,   0, 0, 3, 8'd123, "ld_zw");
    run_txn(1'b1, 16'd200, 8'h5A,  5, 2, 10, 8'd0,  "st_dly");
    run_txn(1'b0, 16'd200, 8'd0,   5, 2, 10, 8'h5A, "ld_dly");

    // Stale ready blocks acceptance until it falls.
    mem_ready = 1'b1;
    req_write = 1'b1; req_addr = 16'h0040; req_wdata = 8'h33; req_valid = 1'b1;
    #1 check_val("stale req_ready", req_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("stale no_accept", {req_ready, mem_read, mem_write}, 3'b000);
    end
    mem_ready = 1'b0;
    run_txn(1'b1, 16'h0040, 8'h33, 0, 0, 3, 8'd0,  "stale_st");
    run_txn(1'b0, 16'h0040, 8'h00, 1, 0, 4, 8'h33, "stale_ld");

    // Watchdog on the TIMEOUT_CYCLES=8 instance; its responder never answers.
    w_req_write = 1'b0; w_req_addr = 16'd5; w_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_req_valid = 1'b0;
    cyc = 1; strobes = 0; done = 1'b0;
    while (!done && cyc <= 20) begin
      if (w_resp_valid) begin
        done = 1'b1;
      end else begin
        if (w_mem_read) strobes++;
        @(negedge clk);
        cyc++;
      end
    end
    check_val("wd latency", done ? cyc : 0, 9);
    check_val("wd resp_error", w_resp_error, 1);
    check_val("wd resp_rdata", w_resp_rdata, 0);
    check_val("wd strobe_cycles", strobes, 8);
    check_val("wd strobes_at_resp", {w_mem_read, w_mem_write}, 2'b00);
    @(negedge clk);
    check_val("wd strobes_after", {w_mem_read, w_mem_write}, 2'b00);
    check_val("wd ready_again", w_req_ready, 1);

    // Reset during ISSUE.
    req_write = 1'b0; req_addr = 16'd102; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_val("rst_mid mem_read_before", mem_read, 1);
    #2 reset_n = 1'b0;
    #1 check_val("rst_mid mem_read_async", mem_read, 0);
    check_val("rst_mid mem_address", mem_address, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check_val("rst_mid no_resp", pulses, 0);
    run_txn(1'b0, 16'd102, 8'd0, 0, 0, 3, 8'd123, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
